pixel_stream_ctrl: RTL and testbench
====================================

# pixel_stream_ctrl

Raster-scan sequencer for the image-processing pixel datapath. It generates the VSYNC start-up window, the per-line HSYNC blanking window and the row/column/linear addresses for a two-pixel-per-beat stream, and it applies a valid/ready handshake toward the downstream image writer so the stream can be stalled. It sits between the frame-start control and the pixel-operation datapath, which indexes the R/G/B planes using the addresses it emits. It also reports frame completion and keeps a frame count.

## Interface
Parameters:
- `WIDTH`, 768, pixels per line; must be even and ≥ 2.
- `HEIGHT`, 512, lines per frame; must be ≥ 1.
- `START_UP_DELAY`, 100, VSYNC window length in cycles; must be ≥ 1.
- `HSYNC_DELAY`, 160, blanking cycles before each line; must be ≥ 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `HCLK` input 1: the single clock.
  - `HRESETn` input 1: asynchronous, active-low reset.
- `start` input 1: frame request pulse; sampled only in IDLE.
- `abort` input 1: synchronous abort; returns to IDLE from any state.
- `out_ready` input 1: downstream accepts the current beat.
- `VSYNC` output 1: high throughout the VSYNC state.
- `HSYNC` output 1: high while a line's data beats are presented (DATA state).
- `out_valid` output 1: the beat on `row`/`col`/`addr` is valid.
- `row` output 10: current line, 0..HEIGHT-1.
- `col` output 11: first pixel of the beat (even), 0..WIDTH-2.
- `addr` output 19: row*WIDTH+col.
- `eol` output 1: current beat is the last beat of its line.
- `eof` output 1: current beat is the last beat of the frame.
- `busy` output 1: state is not IDLE.
- `ctrl_done` output 1: one-cycle pulse when a frame completes.
- `frame_cnt` output 8: completed frames, wraps 255→0.

## Operation
- States: IDLE, VSYNC, HSYNC, DATA, DONE.
- IDLE → VSYNC on `start`=1 with `abort`=0. While not IDLE, `start` is ignored.
- VSYNC lasts exactly START_UP_DELAY cycles, then HSYNC.
- HSYNC lasts exactly HSYNC_DELAY cycles, then DATA.
- DATA:
  - `out_valid`=1. A beat is accepted when `out_valid`&&`out_ready`.
  - On each accept, `col` += 2.
  - On accepting the beat with `col`==WIDTH-2, `col`←0 and `row`+=1, then:
    - if it was not the last line, go to HSYNC;
    - if `row`==HEIGHT-1 (the `eof` beat), go to DONE.
- DONE lasts one cycle: `ctrl_done`=1, `frame_cnt` += 1, then IDLE. `row`/`col` are cleared on entry to DONE.
- `abort`=1 in any state:
  - next state is IDLE;
  - `row`, `col` and the delay counter clear;
  - no `ctrl_done` pulse and no `frame_cnt` change.
  - `abort` in DONE still forces IDLE, but the done pulse of that cycle is kept.
- Stall rule: while `out_valid`&&!`out_ready`, `row`, `col`, `addr`, `eol` and `eof` hold stable. DATA is never left without an accept.
- `addr` is computed combinationally from the registered `row`/`col`. The multiply by constant WIDTH is 19 bits wide, no overflow for the defaults (max 393214).
- Outside DATA: `out_valid`, `HSYNC`, `eol` and `eof` are 0, and `row`/`col` show their held values.
- Delay counter width is $clog2(max(START_UP_DELAY, HSYNC_DELAY)+1). It clears on every state change.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- `start` is sampled at clock edge E; `VSYNC` rises after E, in cycle 1.
- With `out_ready` held at 1, one frame takes START_UP_DELAY + HEIGHT*(HSYNC_DELAY + WIDTH/2) + 1 cycles. The final cycle carries `ctrl_done`.
- Default parameters: 196608 beats per frame; the last beat has `addr`=393214.
- `frame_cnt` updates on the clock edge that ends DONE. It is visible in the cycle after the `ctrl_done` pulse.
- There is no throughput loss beyond the blanking windows; back-to-back accepts advance every cycle.
- A new `start` is accepted at the earliest in the IDLE cycle following DONE.
- Reset asserted mid-frame returns all outputs to 0 immediately (asynchronous).

## Structure
- Shared package `img_pkg`:
  - state enum `stream_state_t`;
  - default WIDTH/HEIGHT/delay constants;
  - `ROW_W`=10, `COL_W`=11, `ADDR_W`=19.
- Sub-module `sync_delay_timer`:
  - loadable down-counter with a `load`/`expire` interface;
  - used for both the VSYNC and HSYNC windows.
- FSM, row/col counters, address generation and frame counter sit in the top.

## Test plan
All scenarios use WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2 unless stated.
- Nominal frame:
  - stimulus: `start` pulse, `out_ready`=1;
  - response: `VSYNC` high cycles 1–3, 16 beats with `addr` 0,2,…,30, `eol` on `col`=6, `eof` on `addr`=30, `ctrl_done` in cycle 28, `frame_cnt` then reads 1.
- Backpressure:
  - stimulus: `out_ready`=0 for 5 cycles at `addr`=10;
  - response: `addr` holds 10 with `out_valid`=1, then resumes at 12; `ctrl_done` arrives 5 cycles later (cycle 33).
- Abort mid-line:
  - stimulus: `abort` at `row`=2, `col`=4;
  - response: next cycle `busy`=0, `row`=`col`=0, no `ctrl_done`, `frame_cnt` unchanged; a following `start` runs a full 28-cycle frame.
- Start and abort together in IDLE, plus start during a frame:
  - stimulus: `start`&&`abort` in IDLE; then `start` pulses during VSYNC/DATA;
  - response: FSM stays IDLE for the simultaneous pulse; the in-frame pulses are ignored and the frame length stays 28.
- Async reset mid-frame:
  - stimulus: `HRESETn` low during DATA;
  - response: all outputs 0 without a clock edge, `frame_cnt`=0.
- Frame counter wrap:
  - stimulus: 256 back-to-back frames;
  - response: `frame_cnt` wraps 255→0 and `ctrl_done` pulses 256 times.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and constants for the raster-scan pixel stream sequencer.
package img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSYNC = 3'd1,
        ST_HSYNC = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } stream_state_t;

    localparam int DEF_WIDTH          = 768;
    localparam int DEF_HEIGHT         = 512;
    localparam int DEF_START_UP_DELAY = 100;
    localparam int DEF_HSYNC_DELAY    = 160;

    localparam int ROW_W  = 10;
    localparam int COL_W  = 11;
    localparam int ADDR_W = 19;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_delay_timer.sv
// Loadable down-counter timing the VSYNC and HSYNC windows; expire is high
// while the count sits at zero.
module sync_delay_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/pixel_stream_ctrl.sv
// Raster-scan sequencer: VSYNC start-up window, per-line blanking, two-pixel
// beats with valid/ready stalling, frame-done pulse and frame counter.
module pixel_stream_ctrl
    import img_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int HEIGHT         = DEF_HEIGHT,
    parameter int START_UP_DELAY = DEF_START_UP_DELAY,
    parameter int HSYNC_DELAY    = DEF_HSYNC_DELAY
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic              out_valid,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              ctrl_done,
    output logic [7:0]        frame_cnt
);

    localparam int DLY_MAX = max_int(START_UP_DELAY, HSYNC_DELAY);
    localparam int CNT_W   = $clog2(DLY_MAX + 1);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 2);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] VS_LOAD  = CNT_W'(START_UP_DELAY - 1);
    localparam logic [CNT_W-1:0] HS_LOAD  = CNT_W'(HSYNC_DELAY - 1);

    // Handshake: a beat transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready low the
    // beat (row/col/addr/eol/eof) is held unchanged and out_valid stays high.

    stream_state_t    state;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             tmr_clear;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;

    assign accept   = out_valid && out_ready;
    assign last_col = (col == LAST_COL);
    assign last_row = (row == LAST_ROW);
    assign eol      = out_valid && last_col;
    assign eof      = eol && last_row;
    assign addr     = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);

    // The timer is reloaded on every state change: with the next window
    // length minus one when entering VSYNC/HSYNC, with zero otherwise.
    always_comb begin
        tmr_clear = abort;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = VS_LOAD;
                end
            end
            ST_VSYNC: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = HS_LOAD;
                end
            end
            ST_HSYNC: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (accept && last_col) begin
                    tmr_load = 1'b1;
                    tmr_val  = last_row ? '0 : HS_LOAD;
                end
            end
            ST_DONE: begin
                tmr_load = 1'b1;
            end
            default: begin
                tmr_load = 1'b1;
            end
        endcase
    end

    sync_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            VSYNC     <= 1'b0;
            HSYNC     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ctrl_done <= 1'b0;
            frame_cnt <= '0;
        end else if (abort) begin
            // The done pulse of an aborted DONE cycle has already been shown;
            // the frame counter is left untouched.
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            VSYNC     <= 1'b0;
            HSYNC     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ctrl_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_VSYNC;
                        VSYNC <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_VSYNC: begin
                    if (tmr_expire) begin
                        state <= ST_HSYNC;
                        VSYNC <= 1'b0;
                    end
                end
                ST_HSYNC: begin
                    if (tmr_expire) begin
                        state     <= ST_DATA;
                        HSYNC     <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        if (last_col) begin
                            col       <= '0;
                            HSYNC     <= 1'b0;
                            out_valid <= 1'b0;
                            if (last_row) begin
                                row       <= '0;
                                state     <= ST_DONE;
                                ctrl_done <= 1'b1;
                            end else begin
                                row   <= row + ROW_W'(1);
                                state <= ST_HSYNC;
                            end
                        end else begin
                            col <= col + COL_W'(2);
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    ctrl_done <= 1'b0;
                    frame_cnt <= frame_cnt + 8'd1;
                end
                default: begin
                    state     <= ST_IDLE;
                    VSYNC     <= 1'b0;
                    HSYNC     <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    ctrl_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// Bench for pixel_stream_ctrl: randomized frames with backpressure, aborts and
// stray starts, checked against a beat scoreboard and frame-timing arithmetic.
module tb_pixel_stream_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int SU = 3;
    localparam int HS = 2;
    localparam int BUDGET = 400;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        VSYNC, HSYNC, out_valid, eol, eof, busy, ctrl_done;
    logic [9:0]  row;
    logic [10:0] col;
    logic [18:0] addr;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad = 0;
    int exp_frames = 0;
    logic [18:0] exp_q[$];

    pixel_stream_ctrl #(
        .WIDTH          (W),
        .HEIGHT         (H),
        .START_UP_DELAY (SU),
        .HSYNC_DELAY    (HS)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start     (start),
        .abort     (abort),
        .out_ready (out_ready),
        .VSYNC     (VSYNC),
        .HSYNC     (HSYNC),
        .out_valid (out_valid),
        .row       (row),
        .col       (col),
        .addr      (addr),
        .eol       (eol),
        .eof       (eof),
        .busy      (busy),
        .ctrl_done (ctrl_done),
        .frame_cnt (frame_cnt)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [54:0] all_outputs();
        return {VSYNC, HSYNC, out_valid, row, col, addr, eol, eof, busy, ctrl_done, frame_cnt};
    endfunction

    // Runs one frame starting at a falling edge with the DUT idle. done_c is
    // the cycle index of ctrl_done (start edge ends cycle 0), or -1 on abort.
    task automatic run_frame(input int stall_pct, input int abort_cycle, input bit noisy,
                             input int stall_addr, input int stall_len, output int done_c);
        int c = 1;
        int stalls = 0;
        int vs_cnt = 0;
        int vs_bad = 0;
        int blank_cnt = 0;
        int quiet_bad = 0;
        int stall_left = stall_len;
        bit prev_stall = 0;
        bit finished = 0;
        logic [39:0] prev_beat = '0;
        logic [18:0] a;

        done_c = -1;
        exp_q.delete();
        for (int r = 0; r < H; r++)
            for (int k = 0; k < W; k += 2)
                exp_q.push_back(19'(r * W + k));

        start = 1'b1;
        abort = 1'b0;
        out_ready = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);

        while (!finished && c < BUDGET) begin
            if (c == 1) check("vsync_rise", VSYNC, 1);
            if (VSYNC) begin
                vs_cnt++;
                if (c > SU) vs_bad++;
            end
            if (busy && !VSYNC && !out_valid && !ctrl_done) blank_cnt++;
            if (!out_valid && (eol || eof || HSYNC)) quiet_bad++;
            if (prev_stall)
                check("stall_hold", {out_valid, row, col, addr}, {1'b1, prev_beat});

            if (ctrl_done) begin
                done_c = c;
                check("frame_len", c, SU + H * (HS + W / 2) + stalls + 1);
                check("vsync_cycles", vs_cnt, SU);
                check("vsync_late", vs_bad, 0);
                check("blank_cycles", blank_cnt, H * HS);
                check("quiet_flags", quiet_bad, 0);
                check("beats_left", exp_q.size(), 0);
                start = 1'b0;
                out_ready = 1'b1;
                @(posedge HCLK);
                @(negedge HCLK);
                exp_frames = (exp_frames + 1) % 256;
                check("idle_after_done", busy, 0);
                check("done_one_cycle", ctrl_done, 0);
                check("frame_cnt", frame_cnt, exp_frames);
                finished = 1;
            end else if (c == abort_cycle) begin
                if (out_valid && exp_q.size() > 0) check("abort_beat", addr, exp_q[0]);
                start = 1'b0;
                abort = 1'b1;
                out_ready = 1'b1;
                @(posedge HCLK);
                @(negedge HCLK);
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_rowcol", {row, col}, 0);
                check("abort_valid", {out_valid, VSYNC, HSYNC}, 0);
                check("abort_no_done", ctrl_done, 0);
                check("abort_frame_cnt", frame_cnt, exp_frames);
                finished = 1;
            end else begin
                if (out_valid && stall_addr >= 0 && addr == 19'(stall_addr) && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = ($urandom_range(0, 99) >= stall_pct);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        a = exp_q.pop_front();
                        check("addr", addr, a);
                        check("row", row, a / W);
                        check("col", col, a % W);
                        check("eol", eol, (a % W) == W - 2);
                        check("eof", eof, a == W * H - 2);
                    end
                end
                prev_stall = out_valid && !out_ready;
                if (prev_stall) stalls++;
                prev_beat = {row, col, addr};
                start = noisy && ($urandom_range(0, 3) == 0);
                @(posedge HCLK);
                @(negedge HCLK);
                c++;
            end
        end
        check("frame_timeout", finished, 1);
    endtask

    initial begin
        int d;
        int pulses;
        int ab;

        #12;
        check("reset_outputs", all_outputs(), 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("idle_after_reset", busy, 0);

        run_frame(0, -1, 0, -1, 0, d);
        check("nominal_done_cycle", d, 28);

        run_frame(0, -1, 0, 10, 5, d);
        check("bp_done_cycle", d, 33);

        run_frame(0, 20, 0, -1, 0, d);
        run_frame(0, -1, 0, -1, 0, d);
        check("post_abort_done_cycle", d, 28);

        start = 1'b1;
        abort = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", {busy, VSYNC}, 0);
        @(posedge HCLK);
        @(negedge HCLK);
        check("start_abort_still_idle", busy, 0);

        run_frame(0, -1, 1, -1, 0, d);
        check("noisy_start_done_cycle", d, 28);

        for (int i = 0; i < 14; i++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 27)) : -1;
            run_frame(int'($urandom_range(0, 50)), ab, bit'($urandom_range(0, 1)), -1, 0, d);
        end

        start = 1'b1;
        out_ready = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        start = 1'b0;
        repeat (7) @(negedge HCLK);
        check("pre_reset_valid", out_valid, 1);
        #3 HRESETn = 1'b0;
        #1 check("async_reset_outputs", all_outputs(), 0);
        exp_frames = 0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            run_frame(0, -1, 0, -1, 0, d);
            if (d > 0) pulses++;
        end
        check("wrap_done_pulses", pulses, 256);
        check("wrap_frame_cnt", frame_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
